// File: rtl/tile_scan_pkg.sv
// Shared types and CRC-8 constants for the tile scan-chain loader.
// The readback CRC is only built when TILE_SCAN_READBACK_EN is defined.
package tile_scan_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_e;

  localparam logic [7:0] CRC_POLY = 8'h07;
  localparam logic [7:0] CRC_INIT = 8'h00;

  // One serial CRC-8 step, MSB-first feedback.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
    logic fb;
    fb = crc[7] ^ din;
    return {crc[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8 accumulator for scan readback; clear wins over enable.
module crc8_serial
  import tile_scan_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [7:0] crc
);

  logic [7:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clr)     crc_d = CRC_INIT;
    else if (en) crc_d = crc8_step(crc_q, din);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) crc_q <= CRC_INIT;
    else        crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/tile_scan_ctrl.sv
// Streams configuration words LSB-first into a set of tile scan chains, one chain at a time.
// Define TILE_SCAN_READBACK_EN to build the serial CRC-8 over the returned scan data.
module tile_scan_ctrl
  import tile_scan_pkg::*;
#(
  parameter int NUM_CHAINS = 2,
  parameter int WORD_W     = 8,
  parameter int LEN_W      = 9
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        abort,
  input  logic [NUM_CHAINS*LEN_W-1:0] chain_len,
  input  logic [WORD_W-1:0]           cfg_data,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  output logic [NUM_CHAINS-1:0]       scan_out,
  output logic [NUM_CHAINS-1:0]       scan_en,
  output logic                        scan_shift,
  input  logic [NUM_CHAINS-1:0]       scan_ret,
  output logic                        busy,
  output logic                        done,
  output logic [7:0]                  rb_crc
);

  localparam int CW = (NUM_CHAINS > 1) ? $clog2(NUM_CHAINS) : 1;
  localparam int BW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  state_e                             state_q, state_d;
  logic [NUM_CHAINS-1:0][LEN_W-1:0]   lens_q, lens_d, lens_in;
  logic [CW-1:0]                      act_q, act_d;
  logic [WORD_W-1:0]                  word_q, word_d;
  logic [BW-1:0]                      bit_q, bit_d;
  logic [LEN_W-1:0]                   rem_q, rem_d;
  logic                               pend_q, pend_d;
  logic                               first_found, next_found;
  logic [CW-1:0]                      first_idx, next_idx;
  logic                               start_acc;

  assign lens_in = chain_len;

  // Lowest nonzero chain overall (for start) and lowest nonzero chain above the active one.
  always_comb begin
    first_found = 1'b0;
    first_idx   = '0;
    next_found  = 1'b0;
    next_idx    = '0;
    for (int i = NUM_CHAINS - 1; i >= 0; i--) begin
      if (lens_in[i] != '0) begin
        first_found = 1'b1;
        first_idx   = CW'(i);
      end
      if (i > int'(act_q) && lens_q[i] != '0) begin
        next_found = 1'b1;
        next_idx   = CW'(i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    lens_d    = lens_q;
    act_d     = act_q;
    word_d    = word_q;
    bit_d     = bit_q;
    rem_d     = rem_q;
    pend_d    = pend_q;
    start_acc = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          lens_d    = lens_in;
          if (first_found) begin
            act_d   = first_idx;
            rem_d   = lens_in[first_idx];
            state_d = S_LOAD;
          end else begin
            // Empty load still spends one cycle so done never coincides with start.
            pend_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_LOAD: begin
        if (cfg_valid) begin
          word_d  = cfg_data;
          bit_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        word_d = word_q >> 1;
        bit_d  = bit_q + BW'(1);
        rem_d  = rem_q - LEN_W'(1);
        if (rem_q == LEN_W'(1)) begin
          if (next_found) begin
            act_d   = next_idx;
            rem_d   = lens_q[next_idx];
            state_d = S_LOAD;
          end else begin
            state_d = S_DONE;
          end
        end else if (bit_q == BW'(WORD_W - 1)) begin
          state_d = S_LOAD;
        end
      end
      S_DONE: begin
        if (pend_q) pend_d  = 1'b0;
        else        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      pend_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      lens_q  <= '0;
      act_q   <= '0;
      word_q  <= '0;
      bit_q   <= '0;
      rem_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lens_q  <= lens_d;
      act_q   <= act_d;
      word_q  <= word_d;
      bit_q   <= bit_d;
      rem_q   <= rem_d;
      pend_q  <= pend_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign cfg_ready  = (state_q == S_LOAD) && !abort;
  assign scan_shift = (state_q == S_SHIFT);
  assign done       = (state_q == S_DONE) && !pend_q && !abort;

  for (genvar g = 0; g < NUM_CHAINS; g++) begin : g_lane
    assign scan_en[g]  = (state_q == S_LOAD || state_q == S_SHIFT) && (act_q == CW'(g));
    assign scan_out[g] = scan_shift && (act_q == CW'(g)) && word_q[0];
  end

`ifdef TILE_SCAN_READBACK_EN
  crc8_serial u_crc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_acc),
    .en    (scan_shift),
    .din   (scan_ret[act_q]),
    .crc   (rb_crc)
  );
`else
  logic unused_ret;
  assign unused_ret = ^{scan_ret, start_acc};
  assign rb_crc     = CRC_INIT;
`endif

endmodule

// File: tb/tb_tile_scan_ctrl.sv
// Scoreboard bench for tile_scan_ctrl: expected scan bits queued at launch, compared after done.
module tb_tile_scan_ctrl;

  localparam int NC = 2;
  localparam int W  = 8;
  localparam int LW = 9;

  typedef logic [2*NC-1:0] ent_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic [NC*LW-1:0] chain_len = '0;
  logic [W-1:0]    cfg_data = '0;
  logic            cfg_valid = 1'b0;
  logic            cfg_ready;
  logic [NC-1:0]   scan_out, scan_en, scan_ret = '0;
  logic            scan_shift, busy, done;
  logic [7:0]      rb_crc;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, acc_cnt = 0, stall_at = -1, stall_len = 0, stall_cnt = 0;
  int done_cnt = 0, done_cyc = 0, start_cyc = 0, overlap = 0, act_seen = 0;
  logic [7:0] mcrc = 8'h00, done_crc = 8'h00;
  ent_t exp_q[$], obs_q[$];
  logic [7:0] words[$];

  tile_scan_ctrl #(.NUM_CHAINS(NC), .WORD_W(W), .LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .chain_len(chain_len),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .scan_out(scan_out), .scan_en(scan_en), .scan_shift(scan_shift), .scan_ret(scan_ret),
    .busy(busy), .done(done), .rb_crc(rb_crc)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] crc_ref(input logic [7:0] c, input logic b);
    logic fb;
    fb = c[7] ^ b;
    return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (cfg_valid && cfg_ready) acc_cnt++;
  end

  // Word source: presents words[acc_cnt], optionally withholding valid for stall_len LOAD cycles.
  always @(negedge clk) begin
    if (acc_cnt < words.size()) begin
      cfg_data = words[acc_cnt];
      if (acc_cnt == stall_at && stall_cnt < stall_len) begin
        cfg_valid = 1'b0;
        if (cfg_ready) stall_cnt++;
      end else begin
        cfg_valid = 1'b1;
      end
    end else begin
      cfg_valid = 1'b0;
      cfg_data  = '0;
    end
  end

  always @(negedge clk) begin
    if (scan_shift) begin
      if (obs_q.size() < exp_q.size())
        mcrc = crc_ref(mcrc, |(scan_ret & exp_q[obs_q.size()][2*NC-1:NC]));
      obs_q.push_back({scan_en, scan_out});
      if (cfg_ready) overlap++;
    end
    if (scan_en != '0 || scan_shift) act_seen++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      done_crc = rb_crc;
    end
  end

  task automatic push_bits(input int ch, input logic [7:0] w, input int n);
    ent_t e;
    for (int i = 0; i < n; i++) begin
      e = '0;
      e[NC+ch] = 1'b1;
      e[ch] = w[i];
      exp_q.push_back(e);
    end
  endtask

  task automatic launch(input logic [LW-1:0] l0, input logic [LW-1:0] l1);
    @(negedge clk);
    chain_len = {l1, l0};
    obs_q.delete();
    acc_cnt = 0; stall_cnt = 0; mcrc = 8'h00; act_seen = 0; overlap = 0;
    start = 1'b1;
    @(posedge clk);
    #1 start_cyc = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit to);
    int d0;
    d0 = done_cnt;
    to = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (done_cnt != d0) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    #2;
    n_cmp++;
    if ({cfg_ready, scan_out, scan_en, scan_shift, busy, done, rb_crc} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b want all zero",
               {cfg_ready, scan_out, scan_en, scan_shift, busy, done, rb_crc});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_bad++; $display("FAIL reset_idle: busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_basic;
    bit to;
    exp_q.delete(); words = '{8'hA5, 8'h06}; scan_ret = '0;
    push_bits(0, 8'hA5, 8); push_bits(1, 8'h06, 3);
    launch(9'd8, 9'd3);
    wait_done(60, to);
    n_cmp++; if (to) begin n_bad++; $display("FAIL basic_timeout: no done within 60 cycles"); end
    n_cmp++;
    if (done_cyc - start_cyc != 13) begin
      n_bad++; $display("FAIL basic_latency: got %0d edges want 13", done_cyc - start_cyc);
    end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL basic_count: got %0d shifts want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL basic_bit%0d: got en/out %b want %b", i, obs_q[i], exp_q[i]);
      end
    end
    @(negedge clk); @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || scan_en !== '0) begin
      n_bad++; $display("FAIL basic_idle: busy=%b scan_en=%b want 0", busy, scan_en);
    end
  endtask

  task automatic test_zero;
    bit to;
    exp_q.delete(); words.delete();
    launch(9'd0, 9'd0);
    wait_done(20, to);
    n_cmp++; if (to) begin n_bad++; $display("FAIL zero_timeout: no done within 20 cycles"); end
    n_cmp++;
    if (done_cyc - start_cyc != 1) begin
      n_bad++; $display("FAIL zero_latency: got %0d edges want 1", done_cyc - start_cyc);
    end
    n_cmp++;
    if (act_seen != 0) begin
      n_bad++; $display("FAIL zero_activity: got %0d active cycles want 0", act_seen);
    end
    @(negedge clk); @(negedge clk);
  endtask

  task automatic test_stall;
    bit to;
    exp_q.delete(); words = '{8'hA5, 8'h06}; scan_ret = '0;
    stall_at = 1; stall_len = 5;
    push_bits(0, 8'hA5, 8); push_bits(1, 8'h06, 3);
    launch(9'd8, 9'd3);
    wait_done(60, to);
    stall_at = -1;
    n_cmp++; if (to) begin n_bad++; $display("FAIL stall_timeout: no done within 60 cycles"); end
    n_cmp++;
    if (done_cyc - start_cyc != 18) begin
      n_bad++; $display("FAIL stall_latency: got %0d edges want 18", done_cyc - start_cyc);
    end
    n_cmp++;
    if (overlap != 0) begin
      n_bad++; $display("FAIL stall_shift: got %0d shift cycles while loading want 0", overlap);
    end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL stall_count: got %0d shifts want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL stall_bit%0d: got en/out %b want %b", i, obs_q[i], exp_q[i]);
      end
    end
    @(negedge clk); @(negedge clk);
  endtask

  task automatic test_multi_word;
    bit to;
    exp_q.delete(); words = '{8'h5A, 8'hFF}; scan_ret = 2'b10;
    push_bits(1, 8'h5A, 8); push_bits(1, 8'hFF, 2);
    launch(9'd0, 9'd10);
    wait_done(60, to);
    n_cmp++; if (to) begin n_bad++; $display("FAIL multi_timeout: no done within 60 cycles"); end
    n_cmp++;
    if (done_cyc - start_cyc != 12) begin
      n_bad++; $display("FAIL multi_latency: got %0d edges want 12", done_cyc - start_cyc);
    end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL multi_count: got %0d shifts want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL multi_bit%0d: got en/out %b want %b", i, obs_q[i], exp_q[i]);
      end
    end
    n_cmp++;
`ifdef TILE_SCAN_READBACK_EN
    if (done_crc !== mcrc) begin
      n_bad++; $display("FAIL multi_crc: got %h want %h", done_crc, mcrc);
    end
`else
    if (done_crc !== 8'h00) begin
      n_bad++; $display("FAIL multi_crc: got %h want 00", done_crc);
    end
`endif
    scan_ret = '0;
    @(negedge clk); @(negedge clk);
  endtask

  task automatic test_abort;
    bit to;
    int d0;
    exp_q.delete(); words = '{8'hA5, 8'h06}; scan_ret = '0;
    push_bits(0, 8'hA5, 8); push_bits(1, 8'h06, 3);
    d0 = done_cnt;
    launch(9'd8, 9'd3);
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (scan_shift !== 1'b1) begin
      n_bad++; $display("FAIL abort_in_shift: scan_shift=%b want 1", scan_shift);
    end
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || scan_en !== '0) begin
      n_bad++; $display("FAIL abort_idle: busy=%b scan_en=%b want 0", busy, scan_en);
    end
    repeat (20) @(negedge clk);
    n_cmp++;
    if (done_cnt != d0) begin
      n_bad++; $display("FAIL abort_nodone: got %0d done pulses want 0", done_cnt - d0);
    end
    n_cmp++;
    if (obs_q.size() != 4) begin
      n_bad++; $display("FAIL abort_shifts: got %0d shifts want 4", obs_q.size());
    end
    launch(9'd8, 9'd3);
    wait_done(60, to);
    n_cmp++; if (to) begin n_bad++; $display("FAIL rerun_timeout: no done within 60 cycles"); end
    n_cmp++;
    if (done_cyc - start_cyc != 13) begin
      n_bad++; $display("FAIL rerun_latency: got %0d edges want 13", done_cyc - start_cyc);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL rerun_bit%0d: got en/out %b want %b", i,
                 (i < obs_q.size()) ? obs_q[i] : ent_t'('x), exp_q[i]);
      end
    end
    @(negedge clk); @(negedge clk);
  endtask

  task automatic test_start_busy;
    bit to;
    int d0;
    exp_q.delete(); words = '{8'hA5, 8'h06}; scan_ret = '0;
    push_bits(0, 8'hA5, 8); push_bits(1, 8'h06, 3);
    d0 = done_cnt;
    launch(9'd8, 9'd3);
    repeat (3) @(negedge clk);
    chain_len = {9'd1, 9'd1};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(60, to);
    n_cmp++; if (to) begin n_bad++; $display("FAIL busy_timeout: no done within 60 cycles"); end
    n_cmp++;
    if (done_cyc - start_cyc != 13) begin
      n_bad++; $display("FAIL busy_latency: got %0d edges want 13", done_cyc - start_cyc);
    end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL busy_count: got %0d shifts want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL busy_bit%0d: got en/out %b want %b", i, obs_q[i], exp_q[i]);
      end
    end
    repeat (10) @(negedge clk);
    n_cmp++;
    if (done_cnt - d0 != 1) begin
      n_bad++; $display("FAIL busy_one_done: got %0d done cycles want 1", done_cnt - d0);
    end
  endtask

  task automatic test_crc;
    bit to;
    exp_q.delete(); words = '{8'h3C}; scan_ret = 2'b01;
    push_bits(0, 8'h3C, 8);
    launch(9'd8, 9'd0);
    wait_done(40, to);
    n_cmp++; if (to) begin n_bad++; $display("FAIL crc_timeout: no done within 40 cycles"); end
    n_cmp++;
    if (done_cyc - start_cyc != 9) begin
      n_bad++; $display("FAIL crc_latency: got %0d edges want 9", done_cyc - start_cyc);
    end
    n_cmp++;
`ifdef TILE_SCAN_READBACK_EN
    if (done_crc !== 8'hF3) begin
      n_bad++; $display("FAIL crc_value: got %h want f3", done_crc);
    end
`else
    if (done_crc !== 8'h00) begin
      n_bad++; $display("FAIL crc_value: got %h want 00", done_crc);
    end
`endif
    scan_ret = '0;
    @(negedge clk); @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int d0;
    exp_q.delete(); words = '{8'hA5, 8'h06};
    launch(9'd8, 9'd3);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({cfg_ready, scan_out, scan_en, scan_shift, busy, done, rb_crc} !== '0) begin
      n_bad++;
      $display("FAIL midreset_outputs: got %b want all zero",
               {cfg_ready, scan_out, scan_en, scan_shift, busy, done, rb_crc});
    end
    d0 = done_cnt;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    n_cmp++;
    if (done_cnt != d0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL midreset_idle: done pulses=%0d busy=%b want 0 0", done_cnt - d0, busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_stall();
    test_multi_word();
    test_abort();
    test_start_busy();
    test_crc();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1);
  end

endmodule
